// File: rtl/snn_pkg.sv
// Shared sizing and types for the SNN input delay stage.
// Imported by the delay channel and the stage top.
package snn_pkg;

  localparam int NUM_INPUTS = 8;
  localparam int DELAY_W    = 3;
  localparam int ADDR_W     = 3;
  localparam int MAX_DELAY  = (1 << DELAY_W) - 1;

  typedef logic [NUM_INPUTS-1:0] spike_vec_t;
  typedef logic [DELAY_W-1:0]    delay_t;

endpackage

// File: rtl/snn_delay_channel.sv
// One axonal delay channel: spike history, delay register and tap mux.
// Tap 0 is the live input; tap j is the sample taken j ticks earlier.
module snn_delay_channel
  import snn_pkg::*;
#(
  parameter int RESET_DELAY = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr_i,
  input  logic   shift_i,
  input  logic   we_i,
  input  delay_t wdata_i,
  input  logic   spike_i,
  output logic   spike_o,
  output delay_t dly_o
);

  logic [MAX_DELAY-1:0] hist_q, hist_d;
  delay_t               dly_q, dly_d;
  logic                 out_q, out_d;
  logic [MAX_DELAY:0]   taps;

  assign taps = {hist_q, spike_i};

  always_comb begin
    hist_d = hist_q;
    out_d  = out_q;
    dly_d  = dly_q;
    if (clr_i) begin
      hist_d = '0;
      out_d  = 1'b0;
    end else if (shift_i) begin
      out_d  = taps[dly_q];
      hist_d = {hist_q[MAX_DELAY-2:0], spike_i};
    end
    if (we_i) begin
      dly_d = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      out_q  <= 1'b0;
      dly_q  <= delay_t'(RESET_DELAY);
    end else begin
      hist_q <= hist_d;
      out_q  <= out_d;
      dly_q  <= dly_d;
    end
  end

  assign spike_o = out_q;
  assign dly_o   = dly_q;

endmodule

// File: rtl/snn_input_delay_stage.sv
// Per-channel programmable axonal delay between ui_in and the neuron layer.
// Handles tick/ena/flush gating, config decode, readback and spike_valid.
module snn_input_delay_stage
  import snn_pkg::*;
#(
  parameter int RESET_DELAY = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  tick,
  input  logic [NUM_INPUTS-1:0] spike_in,
  input  logic                  flush,
  input  logic                  cfg_we,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [DELAY_W-1:0]    cfg_delay,
  output logic [NUM_INPUTS-1:0] spike_out,
  output logic                  spike_valid,
  output logic [DELAY_W-1:0]    cfg_rdata
);

  logic   acc;
  logic   shift;
  logic   wr_en;
  logic   valid_q, valid_d;
  delay_t dly [NUM_INPUTS];

  assign acc   = ena & tick;
  assign shift = acc & ~flush;
  assign wr_en = ena & cfg_we;

  // Out-of-range addresses match no channel, so writes drop naturally.
  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
    snn_delay_channel #(
      .RESET_DELAY(RESET_DELAY)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (flush),
      .shift_i(shift),
      .we_i   (wr_en & (cfg_addr == ADDR_W'(g))),
      .wdata_i(cfg_delay),
      .spike_i(spike_in[g]),
      .spike_o(spike_out[g]),
      .dly_o  (dly[g])
    );
  end

  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (cfg_addr == ADDR_W'(i)) begin
        cfg_rdata = dly[i];
      end
    end
  end

  assign valid_d = shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign spike_valid = valid_q;

endmodule

// File: tb/tb_snn_input_delay_stage.sv
// Randomized and directed checks of snn_input_delay_stage against
// a queue-based model of past tick samples.
module tb_snn_input_delay_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       tick;
  logic [7:0] spike_in;
  logic       flush;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [2:0] cfg_delay;
  logic [7:0] spike_out;
  logic       spike_valid;
  logic [2:0] cfg_rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m_hist [$];
  int         m_dly [8];
  logic [7:0] m_out;
  logic       m_val;

  snn_input_delay_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .tick       (tick),
    .spike_in   (spike_in),
    .flush      (flush),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_delay  (cfg_delay),
    .spike_out  (spike_out),
    .spike_valid(spike_valid),
    .cfg_rdata  (cfg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    foreach (m_dly[i]) m_dly[i] = 0;
    m_out = '0;
    m_val = 1'b0;
  endtask

  // Expected output: the sample from d accepted ticks ago (d=0 is live).
  task automatic model_step(input bit e, t, f, w, input logic [2:0] a,
                            input logic [2:0] d, input logic [7:0] s);
    if (f) begin
      m_hist.delete();
      m_out = '0;
      m_val = 1'b0;
    end else if (e && t) begin
      for (int i = 0; i < 8; i++) begin
        if (m_dly[i] == 0) m_out[i] = s[i];
        else if (m_hist.size() >= m_dly[i]) m_out[i] = m_hist[m_dly[i]-1][i];
        else m_out[i] = 1'b0;
      end
      m_hist.push_front(s);
      if (m_hist.size() > 7) void'(m_hist.pop_back());
      m_val = 1'b1;
    end else begin
      m_val = 1'b0;
    end
    if (e && w) m_dly[a] = int'(d);
  endtask

  task automatic cyc(input bit e, t, f, w, input logic [2:0] a,
                     input logic [2:0] d, input logic [7:0] s);
    @(negedge clk);
    ena = e; tick = t; flush = f; cfg_we = w;
    cfg_addr = a; cfg_delay = d; spike_in = s;
    model_step(e, t, f, w, a, d, s);
    @(posedge clk);
    #1;
    chk("spike_out", 32'(spike_out), 32'(m_out));
    chk("spike_valid", 32'(spike_valid), 32'(m_val));
    chk("cfg_rdata", 32'(cfg_rdata), 32'(m_dly[a]));
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b0; tick = 1'b0; flush = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_delay = '0; spike_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out", 32'(spike_out), 32'h0);
    chk("rst_valid", 32'(spike_valid), 32'h0);
    chk("rst_rdata", 32'(cfg_rdata), 32'h0);

    // 1: zero delay passes straight through
    repeat (3) cyc(1, 1, 0, 0, 3'd0, 3'd0, 8'hFF);
    chk("t1_out", 32'(spike_out), 32'hFF);
    cyc(1, 0, 0, 0, 3'd0, 3'd0, 8'h00);
    for (int a = 0; a < 8; a++) cyc(1, 0, 0, 0, 3'(a), 3'd0, 8'h00);

    // 2: channels 2 and 5 delayed by 3 and 7
    cyc(1, 0, 0, 1, 3'd2, 3'd3, 8'h00);
    cyc(1, 0, 0, 1, 3'd5, 3'd7, 8'h00);
    cyc(1, 1, 0, 0, 3'd2, 3'd0, 8'h24);
    for (int k = 2; k <= 9; k++) begin
      cyc(1, 1, 0, 0, 3'd5, 3'd0, 8'h00);
      if (k == 4) chk("t2_ch2", 32'(spike_out), 32'h04);
      if (k == 8) chk("t2_ch5", 32'(spike_out), 32'h20);
    end

    // 3: disabled block ignores ticks and writes
    cyc(1, 1, 0, 0, 3'd1, 3'd0, 8'hFF);
    repeat (3) cyc(0, 1, 0, 1, 3'd1, 3'd5, 8'hFF);
    chk("t3_rdata", 32'(cfg_rdata), 32'h0);

    // 4: flush wins over tick, delays survive
    cyc(1, 0, 0, 1, 3'd0, 3'd2, 8'h00);
    cyc(1, 1, 0, 0, 3'd0, 3'd0, 8'h01);
    cyc(1, 1, 1, 0, 3'd0, 3'd0, 8'h00);
    chk("t4_flush_valid", 32'(spike_valid), 32'h0);
    repeat (3) cyc(1, 1, 0, 0, 3'd0, 3'd0, 8'h00);
    chk("t4_rdata", 32'(cfg_rdata), 32'h2);

    // 5: same-cycle write and tick uses the old delay
    cyc(1, 0, 0, 1, 3'd0, 3'd0, 8'h00);
    cyc(1, 1, 0, 1, 3'd0, 3'd4, 8'h01);
    chk("t5_old_dly", 32'(spike_out[0]), 32'h1);
    cyc(1, 1, 0, 0, 3'd0, 3'd0, 8'h00);
    chk("t5_new_dly", 32'(spike_out[0]), 32'h0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
          3'($urandom), 3'($urandom), 8'($urandom));
    end

    // 6: asynchronous reset with spikes in flight
    for (int a = 0; a < 8; a++) cyc(1, 0, 0, 1, 3'(a), 3'd5, 8'h00);
    repeat (6) cyc(1, 1, 0, 0, 3'd3, 3'd0, 8'($urandom) | 8'h01);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_out", 32'(spike_out), 32'h0);
    chk("t6_async_valid", 32'(spike_valid), 32'h0);
    model_reset();
    ena = 1'b0; tick = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) cyc(1, 0, 0, 0, 3'(a), 3'd0, 8'h00);
    repeat (8) cyc(1, 1, 0, 0, 3'd0, 3'd0, 8'($urandom));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/snn_input_delay_stage.md
Name: snn_input_delay_stage

Overview:
- Programmable per-channel axonal delay stage between the dedicated input pins (ui_in) and the spiking-neuron layer of the SNN-with-delays top level.
- Samples an 8-bit spike vector on each timestep strobe and presents each channel's spike to the neurons a configured number of timesteps later.
- Per-channel delays are written through a small parallel configuration port driven by the top-level uio pins.

Parameters:
- NUM_INPUTS, 8, number of spike channels.
- DELAY_W, 3, width of a per-channel delay value; maximum delay is MAX_DELAY = 2^DELAY_W - 1 = 7 timesteps.
- RESET_DELAY, 0, delay loaded into every channel at reset.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable; when low, all state holds.
- tick  input  1  one-cycle timestep strobe.
- spike_in  input  NUM_INPUTS  raw spike vector, sampled only on tick.
- flush  input  1  synchronous clear of spike history; delays are kept.
- cfg_we  input  1  configuration write strobe.
- cfg_addr  input  3  channel index to write.
- cfg_delay  input  DELAY_W  delay value to write.
- spike_out  output  NUM_INPUTS  delayed spike vector, registered.
- spike_valid  output  1  one-cycle pulse; high in the cycle after an accepted tick.
- cfg_rdata  output  DELAY_W  delay currently held for channel cfg_addr (combinational read).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All history bits = 0; spike_out = 0; spike_valid = 0.
  - All delay registers = RESET_DELAY.
  - Reset asserted mid-operation discards all in-flight spikes.
- State:
  - Per channel i: history shift register hist[i][0..MAX_DELAY-1] and delay register dly[i].
  - hist[i][0] holds the sample taken at the most recent accepted tick.
- Accepted tick (ena=1 and tick=1), at the clock edge:
  - spike_out[i] <= spike_in[i] if dly[i]==0, else hist[i][dly[i]-1].
  - hist[i][0] <= spike_in[i]; hist[i][j] <= hist[i][j-1] for all j.
  - spike_valid <= 1.
- Latency: a spike sampled at accepted tick k appears on spike_out after the edge of accepted tick k+dly[i]. It persists until the next accepted tick.
- No accepted tick: spike_out and hist hold; spike_valid <= 0.
- ena=0: ticks are ignored, cfg writes are ignored, all state holds. flush still acts.
- Config write (ena=1, cfg_we=1):
  - dly[cfg_addr] <= cfg_delay.
  - If cfg_addr >= NUM_INPUTS, the write is dropped.
- Simultaneous cfg_we and tick on the same channel: the tick uses the old delay; the new delay takes effect from the next tick.
  - History is not altered by a delay change, so spikes already in flight emerge per the new delay's tap position.
- flush=1 (ena ignored):
  - hist <= 0 and spike_out <= 0; spike_valid <= 0.
  - flush has priority over a simultaneous tick, and the tick is lost.
  - Delays are kept; a config write in the same cycle still commits.
- cfg_rdata = dly[cfg_addr], or 0 when cfg_addr is out of range.
- Arithmetic:
  - Tap selection is a pure index mux; there is no wrap-around.
  - The largest delay value selects tap MAX_DELAY-1, so history depth is MAX_DELAY bits per channel.

Decomposition:
- Shared package snn_pkg:
  - NUM_INPUTS, DELAY_W, MAX_DELAY.
  - Typedefs spike_vec_t (NUM_INPUTS bits) and delay_t (DELAY_W bits).
- One sub-module, snn_delay_channel:
  - Covers a single channel's history shift register, delay register, and tap mux.
  - Instantiated NUM_INPUTS times by generate.
  - The top handles ena/tick/flush gating, address decode, spike_valid, and the readback mux.

Test Plan:
1. Reset, then 3 ticks with spike_in=8'hFF and all delays 0 -> spike_out=8'hFF after the first tick; spike_valid pulses once per tick; cfg_rdata=0 for all addresses.
2. Write dly[2]=3 and dly[5]=7. Tick once with spike_in=8'h24, then with spike_in=0 -> spike_out[2]=1 only after the 4th tick (k+3); spike_out[5]=1 only after the 8th tick; all other bits 0.
3. Set ena=0 with tick pulses and cfg_we (addr 1, delay 5) -> spike_out, spike_valid, and cfg_rdata(addr 1) unchanged.
4. dly[0]=2. Tick spike_in=8'h01, then assert flush together with the next tick -> spike_out=0, no spike_valid; 3 further ticks keep spike_out[0]=0; cfg_rdata(0) still 2.
5. Same-cycle cfg_we (addr 0, delay 4) and tick with dly[0]=0 and spike_in=8'h01 -> spike_out[0]=1 immediately (old delay). Next tick spike_in=0 -> spike_out[0]=0, since tap 3 still holds 0.
6. Assert rst_n low asynchronously (mid-clock) with spikes in flight and dly=5 -> spike_out=0 and spike_valid=0 immediately; all dly read back 0 after release.
